// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg: shared defaults, FSM state type and hold-counter sizing
package mux_rr_arbiter_pkg;
  localparam int SEL_W_DEF = 2;
  localparam int MAX_HOLD_DEF = 8;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
  function automatic int hold_w(input int max_hold);
    return $clog2(max_hold) + 1;
  endfunction
endpackage

// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if: request/grant/select bundle between requesters and the arbiter
interface mux_rr_arbiter_if import mux_rr_arbiter_pkg::*; #(parameter int SEL_W = SEL_W_DEF) ();
  localparam int N_REQ = 2 ** SEL_W;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [SEL_W-1:0] selector;
  logic valid;
  logic switch_pulse;
  modport master(input req, output grant, selector, valid, switch_pulse);
  modport slave(output req, input grant, selector, valid, switch_pulse);
endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick: rotating priority encoder, first set req at or after ptr wins, optional masked index
module rr_pick #(parameter int SEL_W = 2) (
  input  logic [2**SEL_W-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  input  logic                mask_en,
  input  logic [SEL_W-1:0]    mask_idx,
  output logic                found,
  output logic [SEL_W-1:0]    idx
);
  // scanning downward lets the closest candidate to ptr overwrite the others
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int k = 2 ** SEL_W - 1; k >= 0; k--)
      if (req[ptr + SEL_W'(k)] && !(mask_en && (ptr + SEL_W'(k)) == mask_idx)) begin
        found = 1'b1;
        idx = ptr + SEL_W'(k);
      end
  end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner of a shared N_REQ:1 mux with hold-limit preemption
module mux_rr_arbiter import mux_rr_arbiter_pkg::*; #(
  parameter int SEL_W = SEL_W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input logic clk,
  input logic rst_n,
  mux_rr_arbiter_if.master bus
);
  localparam int N_REQ = 2 ** SEL_W;
  localparam int HW = hold_w(MAX_HOLD);
  localparam logic [HW-1:0] LAST = HW'(MAX_HOLD - 1);
  state_t state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n, sel_n, pick_idx, nxt;
  logic [N_REQ-1:0] grant_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic sp_n, found, at_limit, rotate;
  assign nxt = bus.selector + SEL_W'(1);
  // while granted, scan starts after the owner and skips it
  rr_pick #(.SEL_W(SEL_W)) u_pick (
    .req(bus.req),
    .ptr(state == ST_GRANT ? nxt : ptr),
    .mask_en(state == ST_GRANT),
    .mask_idx(bus.selector),
    .found(found),
    .idx(pick_idx)
  );
  assign at_limit = (MAX_HOLD != 0) && hold_cnt == LAST;
  assign rotate = !bus.req[bus.selector] || (at_limit && found);
  assign bus.valid = |bus.grant;
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    sel_n = bus.selector;
    grant_n = bus.grant;
    hold_n = hold_cnt;
    sp_n = 1'b0;
    if (state == ST_IDLE) begin
      if (found) begin
        state_n = ST_GRANT;
        sel_n = pick_idx;
        grant_n = N_REQ'(1) << pick_idx;
        hold_n = '0;
        sp_n = 1'b1;
      end
    end else if (rotate) begin
      ptr_n = nxt;
      hold_n = '0;
      state_n = found ? ST_GRANT : ST_IDLE;
      sel_n = found ? pick_idx : bus.selector;
      grant_n = found ? N_REQ'(1) << pick_idx : '0;
      sp_n = found;
    end else
      hold_n = at_limit ? '0 : hold_cnt + HW'(!(&hold_cnt));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr <= '0;
      hold_cnt <= '0;
      bus.grant <= '0;
      bus.selector <= '0;
      bus.switch_pulse <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      hold_cnt <= hold_n;
      bus.grant <= grant_n;
      bus.selector <= sel_n;
      bus.switch_pulse <= sp_n;
    end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: vector table plus scoreboard queue, with hand-written reset sequences
module tb_mux_rr_arbiter;
  typedef struct {
    logic [3:0] req;
    logic [3:0] g;
    logic [1:0] s;
    logic v;
    logic sp;
  } vec_t;
  typedef struct {
    logic [3:0] g;
    logic [1:0] s;
    logic v;
    logic sp;
    int id;
  } exp_t;
  logic clk, rst_n;
  int total = 0, bad = 0, nid = 0;
  vec_t tv[$];
  exp_t q[$];
  exp_t e_cur;
  mux_rr_arbiter_if #(.SEL_W(2)) bus ();
  mux_rr_arbiter #(.SEL_W(2), .MAX_HOLD(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (grant,sel,valid,pulse)", name, act, exp);
    end
  endtask
  task automatic expect_next(input vec_t v);
    bus.req = v.req;
    q.push_back('{v.g, v.s, v.v, v.sp, nid});
    nid++;
  endtask
  task automatic drive(input vec_t v);
    @(negedge clk);
    expect_next(v);
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      e_cur = q.pop_front();
      check($sformatf("vec%0d", e_cur.id), {bus.grant, bus.selector, bus.valid, bus.switch_pulse},
            {e_cur.g, e_cur.s, e_cur.v, e_cur.sp});
      check("invariant", {6'b0, bus.valid == |bus.grant, $onehot0(bus.grant)}, 8'h03);
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int o = 0; o < 4; o++) begin
      tv.push_back('{4'hF, 4'b1 << o, 2'(o), 1'b1, 1'b0});
      tv.push_back('{4'hF, 4'b1 << o, 2'(o), 1'b1, 1'b0});
      tv.push_back('{4'hF & ~(4'b1 << o), 4'b1 << ((o + 1) % 4), 2'((o + 1) % 4), 1'b1, 1'b1});
    end
    tv.push_back('{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1});
    tv.push_back('{4'b0011, 4'b0001, 2'd0, 1'b1, 1'b1});
    for (int c = 1; c <= 32; c++)
      tv.push_back('{4'b0011, 4'b1 << ((c / 8) % 2), 2'((c / 8) % 2), 1'b1, c % 8 == 0});
    tv.push_back('{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1});
    for (int c = 0; c < 19; c++) tv.push_back('{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0});
    tv.push_back('{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0});
    tv.push_back('{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0});
    tv.push_back('{4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1});
    tv.push_back('{4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0});
    rst_n = 1'b0;
    bus.req = 4'hF;
    #3;
    check("reset", {bus.grant, bus.selector, bus.valid, bus.switch_pulse}, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ignored", {bus.grant, bus.selector, bus.valid, bus.switch_pulse}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    expect_next('{4'hF, 4'b0001, 2'd0, 1'b1, 1'b1});
    foreach (tv[i]) drive(tv[i]);
    @(posedge clk);
    #2;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("async_reset", {bus.grant, bus.selector, bus.valid, bus.switch_pulse}, 8'h00);
    #1 rst_n = 1'b1;
    expect_next('{4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1});
    drive('{4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0});
    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", 8'(q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
